axis_bram_adapter_v1_0_sched: RTL and testbench
===============================================

Name: axis_bram_adapter_v1_0_sched

Overview:
- Sequencer and arbiter in front of the AXIS/BRAM adapter controller.
- Shares one adapter, and its BRAM, between one write requester and one read requester.
- Per granted job: latches the job's BRAM row window, drives rw/addr_reload/start/bound into the adapter, gates the upstream and downstream stream handshakes so only the granted direction moves, detects job completion, then enforces a turnaround gap before the next job.

Parameters:
- BRAM_ADDR_LENGTH, 12, width of BRAM row index.
- BRAM_WIDTH_IN_WORD, 36, stream words per BRAM row.
- TURNAROUND_CYCLES, 2, idle cycles after each job (minimum 1).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- wr_req  in  1  write job request, level
- wr_start  in  BRAM_ADDR_LENGTH  first row of write job
- wr_bound  in  BRAM_ADDR_LENGTH  last row of write job, inclusive
- wr_grant  out  1  1-cycle pulse: write job accepted, wr_start/wr_bound sampled
- wr_done  out  1  1-cycle pulse: write job finished
- rd_req, rd_start, rd_bound, rd_grant, rd_done  same as wr_*, for read jobs
- job_err  out  1  1-cycle pulse: granted job had bound < start
- up_valid  in  1  upstream write-data valid
- up_ready  out  1  upstream write-data ready
- dn_valid  out  1  downstream read-data valid
- dn_ready  in  1  downstream read-data ready
- dn_last  out  1  downstream tlast
- rw  out  1  adapter direction: 1 write, 0 read
- addr_reload  out  1  adapter index reload pulse
- bram_start_index  out  BRAM_ADDR_LENGTH  to adapter
- bram_bound_index  out  BRAM_ADDR_LENGTH  to adapter
- stream_in_valid  out  1  to adapter
- stream_in_accep  in  1  from adapter
- stream_out_valid  in  1  from adapter
- stream_out_accep  out  1  to adapter
- stream_out_tlast  in  1  from adapter
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rstn is synchronous, active-low.
- Reset values:
  - state=IDLE.
  - rw, addr_reload, all grant/done/err pulses, busy, up_ready, dn_valid, dn_last, stream_in_valid, stream_out_accep = 0.
  - Indices = 0; last_grant = READ, so write wins the first contention.
  - Reset mid-job aborts the job; no done pulse is issued.
- FSM states: IDLE, LOAD, SETTLE, RUN, TURN.
- IDLE:
  - If only one req is high, grant it.
  - If both are high, grant the direction opposite last_grant (round-robin).
  - Grant cycle: pulse x_grant, latch start/bound, set rw to the job direction (registered), go to LOAD.
  - rw holds its last value while in IDLE.
- Error check in IDLE: if the latched bound < start, pulse job_err and x_done together one cycle after grant, then go to TURN. No adapter activity: no addr_reload, rw unchanged.
- LOAD: addr_reload=1 for exactly one cycle; bram_start_index/bram_bound_index driven from the latches and held stable until the next grant. Go to SETTLE.
- SETTLE: one cycle, so the adapter's internal previous-rw register matches rw. Go to RUN.
- RUN, write job:
  - stream_in_valid = up_valid; up_ready = stream_in_accep.
  - A beat is up_valid & stream_in_accep. Count beats with word_cnt (0..BRAM_WIDTH_IN_WORD-1, wraps) and row_cnt (BRAM_ADDR_LENGTH+1 bits).
  - Done when a beat occurs with word_cnt = BRAM_WIDTH_IN_WORD-1 and row_cnt = bound-start.
  - Total beats = (bound-start+1)*BRAM_WIDTH_IN_WORD.
- RUN, read job:
  - dn_valid = stream_out_valid; stream_out_accep = dn_ready; dn_last = stream_out_tlast.
  - Done on stream_out_valid & dn_ready & stream_out_tlast.
- Outside RUN in the matching direction: up_ready, dn_valid, dn_last, stream_in_valid, stream_out_accep are all 0. These are combinational from state and inputs; no added latency.
- Completion: on the completing beat, register x_done (pulses the next cycle), update last_grant, load the turnaround counter, go to TURN.
- TURN: stay TURNAROUND_CYCLES cycles, then go to IDLE. Requests are ignored during TURN. A request held through TURN is granted in the first IDLE cycle.
- Latency: grant to addr_reload is 1 cycle; grant to first possible beat is 3 cycles.
- Single job window: bound = start gives exactly BRAM_WIDTH_IN_WORD beats. Max window is 2^BRAM_ADDR_LENGTH rows; row_cnt has no overflow.
- Requester contract: after grant a requester may drop req or change its fields. A request still high after done is treated as a new job.

Decomposition:
- Shared package axis_bram_adapter_pkg:
  - State enum {IDLE, LOAD, SETTLE, RUN, TURN}.
  - Direction constants DIR_WR=1, DIR_RD=0.
  - Beat-count width helper.
- Natural sub-module: axis_bram_adapter_v1_0_rr_arb, 2-way round-robin with last_grant register. The beat counter stays inline.

Test Plan:
- Write job start=4, bound=5, up_valid held high -> wr_grant; addr_reload 1 cycle later with start/bound 4/5; exactly 72 beats; wr_done 1 cycle after the 72nd beat; rw=1 throughout.
- Read job start=0, bound=0, dn_ready toggling 1/0 -> dn_valid only in RUN; wr-side ready=0; rd_done after the beat carrying stream_out_tlast; no beat lost or duplicated.
- wr_req and rd_req both high from reset and held -> grants alternate W,R,W,R; each next grant exactly TURNAROUND_CYCLES+1 cycles after the prior done.
- rd job start=10, bound=3 -> job_err and rd_done pulse together; no addr_reload; next grant after TURN.
- rstn low for 1 cycle during RUN of a write job after 20 beats -> all outputs at reset values next cycle; no wr_done; new job restarts cleanly from LOAD.
- Write job with up_valid stalls (random 30% low) over 3 rows -> exactly 108 beats counted, done timing correct.

Source files
------------

// File: rtl/axis_bram_adapter_pkg.sv
// Shared types and helpers for the AXIS/BRAM adapter job sequencer.
package axis_bram_adapter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    TURN
  } state_e;

  localparam logic DIR_WR = 1'b1;
  localparam logic DIR_RD = 1'b0;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int beat_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_bram_adapter_v1_0_rr_arb.sv
// Two-way round-robin arbiter between the write and read requesters.
module axis_bram_adapter_v1_0_rr_arb
  import axis_bram_adapter_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic wr_req_i,
  input  logic rd_req_i,
  input  logic update_i,
  input  logic update_dir_i,
  output logic grant_valid_o,
  output logic grant_dir_o
);

  logic last_grant_q;

  // Starting from READ lets the write side win the first contention.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant_q <= DIR_RD;
    end else if (update_i) begin
      last_grant_q <= update_dir_i;
    end
  end

  always_comb begin
    grant_valid_o = wr_req_i | rd_req_i;
    if (wr_req_i && rd_req_i) begin
      grant_dir_o = ~last_grant_q;
    end else if (wr_req_i) begin
      grant_dir_o = DIR_WR;
    end else begin
      grant_dir_o = DIR_RD;
    end
  end

endmodule

// File: rtl/axis_bram_adapter_v1_0_sched.sv
// Job sequencer sharing one AXIS/BRAM adapter between a write and a read requester.
module axis_bram_adapter_v1_0_sched
  import axis_bram_adapter_pkg::*;
#(
  parameter int BRAM_ADDR_LENGTH   = 12,
  parameter int BRAM_WIDTH_IN_WORD = 36,
  parameter int TURNAROUND_CYCLES  = 2
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        wr_req,
  input  logic [BRAM_ADDR_LENGTH-1:0] wr_start,
  input  logic [BRAM_ADDR_LENGTH-1:0] wr_bound,
  output logic                        wr_grant,
  output logic                        wr_done,
  input  logic                        rd_req,
  input  logic [BRAM_ADDR_LENGTH-1:0] rd_start,
  input  logic [BRAM_ADDR_LENGTH-1:0] rd_bound,
  output logic                        rd_grant,
  output logic                        rd_done,
  output logic                        job_err,
  input  logic                        up_valid,
  output logic                        up_ready,
  output logic                        dn_valid,
  input  logic                        dn_ready,
  output logic                        dn_last,
  output logic                        rw,
  output logic                        addr_reload,
  output logic [BRAM_ADDR_LENGTH-1:0] bram_start_index,
  output logic [BRAM_ADDR_LENGTH-1:0] bram_bound_index,
  output logic                        stream_in_valid,
  input  logic                        stream_in_accep,
  input  logic                        stream_out_valid,
  output logic                        stream_out_accep,
  input  logic                        stream_out_tlast,
  output logic                        busy
);

  localparam int WORD_W = beat_cnt_width(BRAM_WIDTH_IN_WORD);
  localparam int ROW_W  = BRAM_ADDR_LENGTH + 1;
  localparam int TURN_W = beat_cnt_width(TURNAROUND_CYCLES + 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BRAM_WIDTH_IN_WORD - 1);
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURNAROUND_CYCLES);

  state_e                      state_q, state_d;
  logic                        rw_q, rw_d;
  logic [BRAM_ADDR_LENGTH-1:0] start_q, start_d;
  logic [BRAM_ADDR_LENGTH-1:0] bound_q, bound_d;
  logic [WORD_W-1:0]           word_cnt_q, word_cnt_d;
  logic [ROW_W-1:0]            row_cnt_q, row_cnt_d;
  logic [TURN_W-1:0]           turn_cnt_q, turn_cnt_d;
  logic                        wr_done_q, wr_done_d;
  logic                        rd_done_q, rd_done_d;
  logic                        err_q, err_d;

  logic                        grant_valid, grant_dir, grant_fire;
  logic                        arb_update, arb_update_dir;
  logic                        run_wr, run_rd, wr_beat, rd_beat, job_end;
  logic [BRAM_ADDR_LENGTH-1:0] new_start, new_bound;
  logic [ROW_W-1:0]            span;

  axis_bram_adapter_v1_0_rr_arb u_arb (
    .clk          (clk),
    .rstn         (rstn),
    .wr_req_i     (wr_req),
    .rd_req_i     (rd_req),
    .update_i     (arb_update),
    .update_dir_i (arb_update_dir),
    .grant_valid_o(grant_valid),
    .grant_dir_o  (grant_dir)
  );

  // Only the granted direction's handshake is let through, and only while running.
  assign run_wr           = (state_q == RUN) && (rw_q == DIR_WR);
  assign run_rd           = (state_q == RUN) && (rw_q == DIR_RD);
  assign stream_in_valid  = run_wr & up_valid;
  assign up_ready         = run_wr & stream_in_accep;
  assign dn_valid         = run_rd & stream_out_valid;
  assign stream_out_accep = run_rd & dn_ready;
  assign dn_last          = run_rd & stream_out_tlast;

  assign wr_beat = run_wr & up_valid & stream_in_accep;
  assign rd_beat = run_rd & stream_out_valid & dn_ready;
  assign span    = {1'b0, bound_q - start_q};
  assign job_end = (wr_beat && (word_cnt_q == LAST_WORD) && (row_cnt_q == span))
                 | (rd_beat & stream_out_tlast);

  assign grant_fire = rstn && (state_q == IDLE) && grant_valid;
  assign new_start  = (grant_dir == DIR_WR) ? wr_start : rd_start;
  assign new_bound  = (grant_dir == DIR_WR) ? wr_bound : rd_bound;

  assign wr_grant         = grant_fire && (grant_dir == DIR_WR);
  assign rd_grant         = grant_fire && (grant_dir == DIR_RD);
  assign wr_done          = wr_done_q;
  assign rd_done          = rd_done_q;
  assign job_err          = err_q;
  assign rw               = rw_q;
  assign addr_reload      = (state_q == LOAD);
  assign bram_start_index = start_q;
  assign bram_bound_index = bound_q;
  assign busy             = (state_q != IDLE);

  always_comb begin
    // NOTE: every signal gets a default first; a path that skips an assignment would infer a latch.
    state_d        = state_q;
    rw_d           = rw_q;
    start_d        = start_q;
    bound_d        = bound_q;
    word_cnt_d     = word_cnt_q;
    row_cnt_d      = row_cnt_q;
    turn_cnt_d     = turn_cnt_q;
    wr_done_d      = 1'b0;
    rd_done_d      = 1'b0;
    err_d          = 1'b0;
    arb_update     = 1'b0;
    arb_update_dir = rw_q;

    unique case (state_q)
      IDLE: begin
        if (grant_fire) begin
          start_d    = new_start;
          bound_d    = new_bound;
          word_cnt_d = '0;
          row_cnt_d  = '0;
          if (new_bound < new_start) begin
            // Empty window: report and retire the job without touching the adapter.
            err_d          = 1'b1;
            wr_done_d      = (grant_dir == DIR_WR);
            rd_done_d      = (grant_dir == DIR_RD);
            arb_update     = 1'b1;
            arb_update_dir = grant_dir;
            turn_cnt_d     = TURN_LOAD;
            state_d        = TURN;
          end else begin
            rw_d    = grant_dir;
            state_d = LOAD;
          end
        end
      end
      LOAD:   state_d = SETTLE;
      SETTLE: state_d = RUN;
      RUN: begin
        if (wr_beat) begin
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            row_cnt_d  = row_cnt_q + ROW_W'(1);
          end else begin
            word_cnt_d = word_cnt_q + WORD_W'(1);
          end
        end
        if (job_end) begin
          wr_done_d  = (rw_q == DIR_WR);
          rd_done_d  = (rw_q == DIR_RD);
          arb_update = 1'b1;
          turn_cnt_d = TURN_LOAD;
          state_d    = TURN;
        end
      end
      TURN: begin
        // The done cycle plus TURNAROUND_CYCLES quiet cycles precede the next grant.
        if (turn_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q - TURN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
    if (!rstn) begin
      state_q    <= IDLE;
      rw_q       <= 1'b0;
      start_q    <= '0;
      bound_q    <= '0;
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
      turn_cnt_q <= '0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      start_q    <= start_d;
      bound_q    <= bound_d;
      word_cnt_q <= word_cnt_d;
      row_cnt_q  <= row_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      wr_done_q  <= wr_done_d;
      rd_done_q  <= rd_done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_axis_bram_adapter_v1_0_sched.sv
// Scoreboard bench for the adapter sequencer: directed jobs, expected events queued, monitor compares.
module tb_axis_bram_adapter_v1_0_sched;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_start, wr_bound, rd_start, rd_bound;
  logic          wr_grant, wr_done, rd_grant, rd_done, job_err;
  logic          up_valid, up_ready, dn_valid, dn_ready, dn_last;
  logic          rw, addr_reload, busy;
  logic [AW-1:0] bram_start_index, bram_bound_index;
  logic          stream_in_valid, stream_in_accep;
  logic          stream_out_valid, stream_out_accep, stream_out_tlast;

  always #10 clk = ~clk;

  axis_bram_adapter_v1_0_sched #(
    .BRAM_ADDR_LENGTH  (AW),
    .BRAM_WIDTH_IN_WORD(36),
    .TURNAROUND_CYCLES (2)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .wr_req          (wr_req),
    .wr_start        (wr_start),
    .wr_bound        (wr_bound),
    .wr_grant        (wr_grant),
    .wr_done         (wr_done),
    .rd_req          (rd_req),
    .rd_start        (rd_start),
    .rd_bound        (rd_bound),
    .rd_grant        (rd_grant),
    .rd_done         (rd_done),
    .job_err         (job_err),
    .up_valid        (up_valid),
    .up_ready        (up_ready),
    .dn_valid        (dn_valid),
    .dn_ready        (dn_ready),
    .dn_last         (dn_last),
    .rw              (rw),
    .addr_reload     (addr_reload),
    .bram_start_index(bram_start_index),
    .bram_bound_index(bram_bound_index),
    .stream_in_valid (stream_in_valid),
    .stream_in_accep (stream_in_accep),
    .stream_out_valid(stream_out_valid),
    .stream_out_accep(stream_out_accep),
    .stream_out_tlast(stream_out_tlast),
    .busy            (busy)
  );

  typedef enum {EV_WGRANT, EV_RGRANT, EV_RELOAD, EV_WDONE, EV_RDONE, EV_ERR} ev_e;
  typedef struct {
    ev_e kind;
    int  a;
    int  b;
    int  c;
  } ev_t;

  localparam int C_WGRANT = 0, C_RGRANT = 1, C_WDONE = 2, C_RDONE = 3;
  localparam int C_IDLE = 4, C_BEATS20 = 5, C_GRANTS4 = 6;

  ev_t exp_q[$];
  int  n_vec = 0, n_bad = 0, cyc = 0;
  int  beats = 0, mism = 0, grant_cyc = 0, last_beat_cyc = 0, last_done_cyc = -1, n_grants = 0;
  int  stall_pct = 0, accep_stall = 0, rd_total = 36, rd_idx = 0;
  bit  dn_toggle = 1'b0, rd_hs = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // a = -1 in an expected entry means the field is not constrained.
  task automatic sb_compare(input ev_t act);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL sb_unexpected: got %s a=%0d b=%0d c=%0d, required no event",
               act.kind.name(), act.a, act.b, act.c);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != act.kind || (e.a != -1 && e.a != act.a) || e.b != act.b || e.c != act.c) begin
      n_bad++;
      $display("FAIL sb_%s @cyc %0d: got %s a=%0d b=%0d c=%0d, required %s a=%0d b=%0d c=%0d",
               e.kind.name(), cyc, act.kind.name(), act.a, act.b, act.c,
               e.kind.name(), e.a, e.b, e.c);
    end
  endtask

  function automatic void push(input ev_e k, input int a, input int b, input int c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endfunction

  function automatic int out_bits();
    return int'({rw, addr_reload, wr_grant, rd_grant, wr_done, rd_done, job_err, busy,
                 up_ready, dn_valid, dn_last, stream_in_valid, stream_out_accep});
  endfunction

  function automatic bit cond(input int which);
    case (which)
      C_WGRANT:  return wr_grant;
      C_RGRANT:  return rd_grant;
      C_WDONE:   return wr_done;
      C_RDONE:   return rd_done;
      C_IDLE:    return !busy;
      C_BEATS20: return beats >= 20;
      C_GRANTS4: return n_grants >= 4;
      default:   return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      #4;
      if (cond(which)) return;
      @(negedge clk);
    end
    n_vec++;
    n_bad++;
    $display("FAIL timeout_%s: condition not seen within %0d cycles", name, budget);
  endtask

  // Adapter stand-in: upstream source, downstream read data with tlast on the job's last beat.
  initial begin : adapter_model
    up_valid = 1'b0; dn_ready = 1'b1; stream_in_accep = 1'b1;
    stream_out_valid = 1'b0; stream_out_tlast = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rd_hs) rd_idx++;
      if (rd_grant || !rstn) rd_idx = 0;
      up_valid         = ($urandom_range(0, 99) >= stall_pct);
      stream_in_accep  = ($urandom_range(0, 99) >= accep_stall);
      dn_ready         = dn_toggle ? ~dn_ready : 1'b1;
      stream_out_valid = 1'b1;
      stream_out_tlast = (rd_idx == rd_total - 1);
      #1;
      rd_hs = stream_out_valid & stream_out_accep;
    end
  end

  initial begin : monitor
    ev_t act;
    int  leak;
    forever begin
      @(negedge clk);
      #3;
      if (!rstn) begin
        last_done_cyc = -1;
        continue;
      end
      leak = !busy ? int'({up_ready, dn_valid, dn_last, stream_in_valid, stream_out_accep})
           : rw    ? int'({dn_valid, dn_last, stream_out_accep})
           :         int'({up_ready, stream_in_valid});
      check("handshake_gating", leak, 0);
      if (job_err || wr_done || rd_done) begin
        if (job_err) begin
          act.kind = EV_ERR; act.a = int'({job_err, wr_done, rd_done});
          act.b = cyc - grant_cyc; act.c = int'(rw);
        end else begin
          act.kind = wr_done ? EV_WDONE : EV_RDONE; act.a = beats;
          act.b = cyc - last_beat_cyc; act.c = mism;
        end
        last_done_cyc = cyc;
        sb_compare(act);
      end else if (wr_grant || rd_grant) begin
        act.kind = wr_grant ? EV_WGRANT : EV_RGRANT;
        act.a = (last_done_cyc < 0) ? -1 : cyc - last_done_cyc;
        act.b = 0; act.c = 0;
        grant_cyc = cyc; beats = 0; mism = 0; n_grants++;
        sb_compare(act);
      end else if (addr_reload) begin
        act.kind = EV_RELOAD; act.a = int'(bram_start_index);
        act.b = int'(bram_bound_index); act.c = cyc - grant_cyc;
        sb_compare(act);
      end
      if (up_valid && up_ready) begin
        beats++; last_beat_cyc = cyc;
        if (rw !== 1'b1) mism++;
      end
      if (dn_valid && dn_ready) begin
        beats++; last_beat_cyc = cyc;
        if (rw !== 1'b0) mism++;
      end
    end
  end

  task automatic launch(input bit is_wr, input int s, input int b);
    @(negedge clk);
    if (is_wr) begin
      wr_start = AW'(s); wr_bound = AW'(b); wr_req = 1'b1;
    end else begin
      rd_start = AW'(s); rd_bound = AW'(b); rd_req = 1'b1;
    end
    wait_for(is_wr ? C_WGRANT : C_RGRANT, 20, "grant");
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic finish_job(input bit is_wr);
    wait_for(is_wr ? C_WDONE : C_RDONE, 1000, "done");
    wait_for(C_IDLE, 20, "idle");
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rstn = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_start = '0; wr_bound = '0; rd_start = '0; rd_bound = '0;
    repeat (3) @(negedge clk);
    #4;
    check("reset_outputs", out_bits(), 0);
    check("reset_indices", int'({bram_start_index, bram_bound_index}), 0);

    // Both requests held from reset: W,R,W,R with a 3-cycle done-to-grant gap.
    wr_start = 12'd1; wr_bound = 12'd1; rd_start = 12'd2; rd_bound = 12'd3; rd_total = 72;
    for (int j = 0; j < 2; j++) begin
      push(EV_WGRANT, (j == 0) ? -1 : 3, 0, 0); push(EV_RELOAD, 1, 1, 1); push(EV_WDONE, 36, 1, 0);
      push(EV_RGRANT, 3, 0, 0);                 push(EV_RELOAD, 2, 3, 1); push(EV_RDONE, 72, 1, 0);
    end
    @(negedge clk);
    wr_req = 1'b1; rd_req = 1'b1; rstn = 1'b1;
    wait_for(C_GRANTS4, 2000, "contention_grants");
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    finish_job(1'b0);

    // Two-row write, source never stalls.
    push(EV_WGRANT, -1, 0, 0); push(EV_RELOAD, 4, 5, 1); push(EV_WDONE, 72, 1, 0);
    launch(1'b1, 4, 5);
    finish_job(1'b1);

    // Single-row read with dn_ready toggling.
    rd_total = 36; dn_toggle = 1'b1;
    push(EV_RGRANT, -1, 0, 0); push(EV_RELOAD, 0, 0, 1); push(EV_RDONE, 36, 1, 0);
    launch(1'b0, 0, 0);
    finish_job(1'b0);
    dn_toggle = 1'b0;

    // Inverted window: err+done together, no reload; pending write granted after TURN.
    push(EV_RGRANT, -1, 0, 0); push(EV_ERR, 5, 1, 0);
    push(EV_WGRANT, 3, 0, 0);  push(EV_RELOAD, 7, 7, 1); push(EV_WDONE, 36, 1, 0);
    launch(1'b0, 10, 3);
    launch(1'b1, 7, 7);
    finish_job(1'b1);

    // Reset after 20 beats of a write: job aborted silently, then rerun cleanly.
    push(EV_WGRANT, -1, 0, 0); push(EV_RELOAD, 0, 1, 1);
    launch(1'b1, 0, 1);
    wait_for(C_BEATS20, 100, "beats20");
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    #4;
    check("midjob_reset_outputs", out_bits(), 0);
    check("midjob_reset_indices", int'({bram_start_index, bram_bound_index}), 0);
    rstn = 1'b1;
    push(EV_WGRANT, -1, 0, 0); push(EV_RELOAD, 0, 1, 1); push(EV_WDONE, 72, 1, 0);
    launch(1'b1, 0, 1);
    finish_job(1'b1);

    // Three-row write with upstream and adapter stalls.
    stall_pct = 30; accep_stall = 20;
    push(EV_WGRANT, -1, 0, 0); push(EV_RELOAD, 5, 7, 1); push(EV_WDONE, 108, 1, 0);
    launch(1'b1, 5, 7);
    finish_job(1'b1);
    stall_pct = 0; accep_stall = 0;

    repeat (5) @(negedge clk);
    #4;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
